bash_hash_axil_master: RTL and testbench

AXI4-Lite initiator that issues single register accesses from a simple command/response handshake toward the Bash-Hash AXI4-Lite register file. It is the master-side counterpart of the core's AXI4-Lite controller and uses the same data width (XLEN = 32) and address width (ADDRLEN = 6). A firmware sequencer or test harness uses it to write message words and control registers and to read status and digest words. At most one transaction is outstanding at any time.

---
 rtl/bash_hash_axil_master.sv | 166 ++++++++++++++++
 tb/tb_bash_hash_axil_master.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bash_hash_axil_master.sv
// Single-outstanding AXI4-Lite initiator for the Bash-Hash register file.
// Turns a command/response handshake into one AW+W/B or AR/R transaction.
module bash_hash_axil_master #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDRLEN = 6
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRLEN-1:0]   cmd_addr,
  input  logic [XLEN-1:0]      cmd_wdata,
  input  logic [XLEN/8-1:0]    cmd_wstrb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 rsp_err,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  output logic [ADDRLEN-1:0]   m_awaddr,
  output logic [2:0]           m_awprot,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  output logic [XLEN-1:0]      m_wdata,
  output logic [XLEN/8-1:0]    m_wstrb,
  input  logic                 m_bvalid,
  output logic                 m_bready,
  input  logic [1:0]           m_bresp,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  output logic [ADDRLEN-1:0]   m_araddr,
  output logic [2:0]           m_arprot,
  input  logic                 m_rvalid,
  output logic                 m_rready,
  input  logic [XLEN-1:0]      m_rdata,
  input  logic [1:0]           m_rresp
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_e;

  state_e               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 arvalid_q, arvalid_d;
  logic [ADDRLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic [XLEN/8-1:0]    wstrb_q, wstrb_d;
  logic [XLEN-1:0]      rdata_q, rdata_d;
  logic                 err_q, err_d;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = {cmd_addr[ADDRLEN-1:2], 2'b00};
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR_ADDR_DATA: begin
        // AW and W retire independently; move on once both have handshaken
        awvalid_d = awvalid_q && !m_awready;
        wvalid_d  = wvalid_q && !m_wready;
        if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (m_bvalid) begin
          err_d   = m_bresp[1];
          rdata_d = '0;
          state_d = RSP;
        end
      end
      RD_ADDR: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_rvalid) begin
          rdata_d = m_rdata;
          err_d   = m_rresp[1];
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered so cmd_ready stays low through reset and rises on the first edge after
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = (state_q == RSP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign m_awvalid = awvalid_q;
  assign m_awaddr  = addr_q;
  assign m_awprot  = 3'b000;
  assign m_wvalid  = wvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_bready  = (state_q == WR_RESP);
  assign m_arvalid = arvalid_q;
  assign m_araddr  = addr_q;
  assign m_arprot  = 3'b000;
  assign m_rready  = (state_q == RD_DATA);

  logic unused_bits;
  assign unused_bits = ^{cmd_addr[1:0], m_bresp[0], m_rresp[0]};

endmodule

// File: tb/tb_bash_hash_axil_master.sv
// Bench for bash_hash_axil_master: memory-model AXI4-Lite slave with stalls,
// protocol stability monitor, and a word-array reference of expected contents.
module tb_bash_hash_axil_master;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [5:0]  m_awaddr, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  int errors = 0;
  int checks = 0;

  bash_hash_axil_master #(.XLEN(32), .ADDRLEN(6)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  always #5 aclk = ~aclk;

  // Slave state and configuration
  logic [31:0] smem [16];
  logic [31:0] ref_mem [16];
  int          aw_w, w_w, b_w, ar_w, r_w;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic        cfg_rovr;
  logic [31:0] cfg_rdata;
  logic        got_aw, got_w, got_ar, b_issued;
  logic        hs_aw, hs_w, hs_b, hs_ar, hs_r;
  logic [5:0]  s_awaddr, s_araddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;
  int          viol = 0;
  logic        split_seen;
  logic        prev_awpend, prev_wpend, prev_arpend;
  logic [5:0]  prev_awaddr, prev_araddr;
  logic [31:0] prev_wdata;
  logic [3:0]  prev_wstrb;

  task automatic slave_clear;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
    m_bresp = 0; m_rresp = 0; m_rdata = 0;
    got_aw = 0; got_w = 0; got_ar = 0; b_issued = 0;
    prev_awpend = 0; prev_wpend = 0; prev_arpend = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin smem[i] = '0; ref_mem[i] = '0; end
    aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
    cfg_bresp = 0; cfg_rresp = 0; cfg_rovr = 0; cfg_rdata = 0; split_seen = 0;
    hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
    slave_clear();
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        slave_clear();
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
      end else begin
        hs_aw = m_awvalid && m_awready;
        hs_w  = m_wvalid && m_wready;
        hs_b  = m_bvalid && m_bready;
        hs_ar = m_arvalid && m_arready;
        hs_r  = m_rvalid && m_rready;
        if (prev_awpend && (!m_awvalid || m_awaddr !== prev_awaddr)) viol++;
        if (prev_wpend && (!m_wvalid || m_wdata !== prev_wdata || m_wstrb !== prev_wstrb)) viol++;
        if (prev_arpend && (!m_arvalid || m_araddr !== prev_araddr)) viol++;
        prev_awpend = m_awvalid && !m_awready; prev_awaddr = m_awaddr;
        prev_wpend  = m_wvalid && !m_wready;   prev_wdata = m_wdata; prev_wstrb = m_wstrb;
        prev_arpend = m_arvalid && !m_arready; prev_araddr = m_araddr;
        if (got_aw && !m_awvalid && m_wvalid) split_seen = 1;
        if (hs_aw) begin aw_cnt++; s_awaddr = m_awaddr; end
        if (hs_w)  begin w_cnt++; s_wdata = m_wdata; s_wstrb = m_wstrb; end
        if (hs_ar) begin ar_cnt++; s_araddr = m_araddr; end
      end
      @(posedge aclk); #1;
      if (!aresetn) begin
        slave_clear();
      end else begin
        if (hs_aw) begin got_aw = 1; m_awready = 0; end
        if (hs_w)  begin got_w = 1; m_wready = 0; end
        if (hs_b)  begin m_bvalid = 0; b_cnt++; got_aw = 0; got_w = 0; b_issued = 0; end
        if (hs_ar) begin got_ar = 1; m_arready = 0; end
        if (hs_r)  begin m_rvalid = 0; got_ar = 0; end
        if (m_awvalid && !got_aw && !m_awready) begin
          if (aw_w == 0) m_awready = 1; else aw_w--;
        end
        if (m_wvalid && !got_w && !m_wready) begin
          if (w_w == 0) m_wready = 1; else w_w--;
        end
        if (m_arvalid && !got_ar && !m_arready) begin
          if (ar_w == 0) m_arready = 1; else ar_w--;
        end
        if (got_aw && got_w && !b_issued) begin
          if (b_w == 0) begin
            for (int b = 0; b < 4; b++)
              if (s_wstrb[b]) smem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
            m_bvalid = 1; m_bresp = cfg_bresp; b_issued = 1;
          end else b_w--;
        end
        if (got_ar && !m_rvalid) begin
          if (r_w == 0) begin
            m_rvalid = 1; m_rresp = cfg_rresp;
            m_rdata = cfg_rovr ? cfg_rdata : smem[s_araddr[5:2]];
          end else r_w--;
        end
      end
    end
  end

  task automatic slave_set(input int aw, input int w, input int b, input int ar, input int r,
                           input logic [1:0] bresp, input logic [1:0] rresp);
    @(negedge aclk);
    aw_w = aw; w_w = w; b_w = b; ar_w = ar; r_w = r;
    cfg_bresp = bresp; cfg_rresp = rresp;
  endtask

  // Issues one command, measures edges from accept to rsp_valid, holds rsp_ready low `hold` cycles.
  task automatic do_cmd(input logic wr, input logic [5:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic stable, output logic ok);
    int n;
    rd = '0; er = 0; lat = 0; stable = 1; ok = 1;
    @(negedge aclk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
    if (!cmd_ready) begin cmd_valid = 0; ok = 0; return; end
    @(posedge aclk); #1;
    cmd_valid = 0;
    if (wr) for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
    while (!rsp_valid && lat < 100) begin @(posedge aclk); #1; lat++; end
    if (!rsp_valid) begin ok = 0; return; end
    rd = rsp_rdata; er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      if (!rsp_valid || rsp_rdata !== rd || rsp_err !== er || cmd_ready !== 1'b0) stable = 0;
    end
    @(negedge aclk); rsp_ready = 1;
    @(posedge aclk); #1; rsp_ready = 0;
  endtask

  task automatic test_reset;
    aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    #12;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    checks++; if ({rsp_valid, rsp_err, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 7'b0) begin
      errors++; $display("FAIL reset_valids: got %b want 0", {rsp_valid, rsp_err, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}); end
    checks++; if ({m_awaddr, m_araddr, m_wdata, m_wstrb, rsp_rdata} !== '0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {m_awaddr, m_araddr, m_wdata, m_wstrb, rsp_rdata}); end
    @(negedge aclk); #2 aresetn = 1;
    @(posedge aclk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if ({m_awprot, m_arprot} !== 6'b0) begin errors++; $display("FAIL prot: got %b want 0", {m_awprot, m_arprot}); end
  endtask

  task automatic test_write_basic;
    logic [31:0] rd; logic er, st, ok; int lat;
    slave_set(0, 0, 0, 0, 0, 2'b00, 2'b00);
    do_cmd(1, 6'h08, 32'hB194BAC8, 4'hF, 0, rd, er, lat, st, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_basic_timeout: got ok=%b want 1", ok); end
    checks++; if (s_awaddr !== 6'h08) begin errors++; $display("FAIL wr_basic_awaddr: got %h want 08", s_awaddr); end
    checks++; if (s_wdata !== 32'hB194BAC8) begin errors++; $display("FAIL wr_basic_wdata: got %h want b194bac8", s_wdata); end
    // accept cycle, AW/W cycle, B cycle, then rsp_valid in the fourth
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_basic_latency: got %0d edges want 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_basic_err: got %b want 0", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_basic_rdata: got %h want 0", rd); end
  endtask

  task automatic test_write_split;
    logic [31:0] rd; logic er, st, ok; int lat, aw0, w0, b0;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; split_seen = 0;
    slave_set(0, 3, 0, 0, 0, 2'b00, 2'b00);
    do_cmd(1, 6'h10, 32'h1234_5678, 4'h5, 0, rd, er, lat, st, ok);
    checks++; if (!ok) begin errors++; $display("FAIL split_timeout: got ok=%b want 1", ok); end
    checks++; if (split_seen !== 1'b1) begin errors++; $display("FAIL split_awvalid_drop: got %b want 1", split_seen); end
    checks++; if (s_wdata !== 32'h1234_5678 || s_wstrb !== 4'h5) begin
      errors++; $display("FAIL split_wdata: got %h/%h want 12345678/5", s_wdata, s_wstrb); end
    checks++; if (aw_cnt - aw0 != 1 || w_cnt - w0 != 1) begin
      errors++; $display("FAIL split_beats: got aw=%0d w=%0d want 1/1", aw_cnt - aw0, w_cnt - w0); end
    checks++; if (b_cnt - b0 != 1) begin errors++; $display("FAIL split_b_count: got %0d want 1", b_cnt - b0); end
    checks++; if (viol != 0) begin errors++; $display("FAIL split_stability: got %0d violations want 0", viol); end
  endtask

  task automatic test_read_err_hold;
    logic [31:0] rd; logic er, st, ok; int lat, ar0;
    ar0 = ar_cnt;
    slave_set(0, 0, 0, 0, 0, 2'b00, 2'b10);
    cfg_rovr = 1; cfg_rdata = 32'h0A08F53B;
    do_cmd(0, 6'h3C, 32'h0, 4'h0, 5, rd, er, lat, st, ok);
    cfg_rovr = 0;
    checks++; if (!ok) begin errors++; $display("FAIL rd_err_timeout: got ok=%b want 1", ok); end
    checks++; if (rd !== 32'h0A08F53B) begin errors++; $display("FAIL rd_err_rdata: got %h want 0a08f53b", rd); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL rd_err_err: got %b want 1", er); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL rd_err_hold_stable: got %b want 1", st); end
    checks++; if (s_araddr !== 6'h3C || ar_cnt - ar0 != 1) begin
      errors++; $display("FAIL rd_err_ar: got addr=%h n=%0d want 3c/1", s_araddr, ar_cnt - ar0); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d edges want 2", lat); end
  endtask

  task automatic test_addr_align;
    logic [31:0] rd; logic er, st, ok; int lat;
    slave_set(1, 0, 1, 2, 1, 2'b00, 2'b00);
    do_cmd(0, 6'h07, 32'h0, 4'h0, 0, rd, er, lat, st, ok);
    checks++; if (!ok || s_araddr !== 6'h04) begin errors++; $display("FAIL align_araddr: got %h want 04", s_araddr); end
    checks++; if (rd !== ref_mem[1]) begin errors++; $display("FAIL align_rdata: got %h want %h", rd, ref_mem[1]); end
    slave_set(0, 1, 0, 0, 0, 2'b00, 2'b00);
    do_cmd(1, 6'h2B, 32'hCAFE_F00D, 4'hF, 0, rd, er, lat, st, ok);
    checks++; if (!ok || s_awaddr !== 6'h28) begin errors++; $display("FAIL align_awaddr: got %h want 28", s_awaddr); end
  endtask

  task automatic test_reset_mid;
    int n, b0;
    b0 = b_cnt;
    slave_set(0, 0, 20, 0, 0, 2'b00, 2'b00);
    @(negedge aclk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 6'h14; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    @(posedge aclk); #1; cmd_valid = 0;
    n = 0;
    @(negedge aclk);
    while (!m_bready && n < 20) begin @(negedge aclk); n++; end
    checks++; if (m_bready !== 1'b1) begin errors++; $display("FAIL mid_reach_wr_resp: got %b want 1", m_bready); end
    #2 aresetn = 0;
    #1;
    checks++; if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid, cmd_ready} !== 7'b0) begin
      errors++; $display("FAIL mid_async_clear: got %b want 0", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid, cmd_ready}); end
    @(negedge aclk); @(negedge aclk); #2 aresetn = 1;
    @(posedge aclk); #1;
    checks++; if (cmd_ready !== 1'b1 || m_bready !== 1'b0) begin
      errors++; $display("FAIL mid_idle_after_release: got ready=%b bready=%b want 1/0", cmd_ready, m_bready); end
    checks++; if (b_cnt != b0) begin errors++; $display("FAIL mid_no_b: got %0d want 0", b_cnt - b0); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er, st, ok; int lat;
    slave_set(0, 0, 0, 0, 0, 2'b00, 2'b00);
    do_cmd(1, 6'h0C, 32'h55AA_33CC, 4'hF, 0, rd, er, lat, st, ok);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_cmd_ready: got %b want 1", cmd_ready); end
    slave_set(0, 0, 0, 0, 0, 2'b00, 2'b00);
    do_cmd(0, 6'h08, 32'h0, 4'h0, 0, rd, er, lat, st, ok);
    checks++; if (!ok || rd !== 32'hB194BAC8) begin errors++; $display("FAIL b2b_readback: got %h want b194bac8", rd); end
  endtask

  task automatic test_random;
    logic [31:0] rd, d, exp_rd; logic er, st, ok, wr; logic [5:0] a; logic [3:0] s;
    logic [1:0] br, rr; int lat;
    for (int i = 0; i < 100; i++) begin
      wr = 1'($urandom_range(0, 1)); a = 6'($urandom_range(0, 63)); d = $urandom;
      s = 4'($urandom_range(0, 15)); br = 2'($urandom_range(0, 3)); rr = 2'($urandom_range(0, 3));
      exp_rd = wr ? 32'h0 : ref_mem[a[5:2]];
      slave_set($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), br, rr);
      do_cmd(wr, a, d, s, $urandom_range(0, 2), rd, er, lat, st, ok);
      checks++; if (!ok || rd !== exp_rd || st !== 1'b1) begin
        errors++; $display("FAIL rand_%0d_rdata: got %h (ok=%b stable=%b) want %h", i, rd, ok, st, exp_rd); end
      checks++; if (er !== (wr ? br[1] : rr[1])) begin
        errors++; $display("FAIL rand_%0d_err: got %b want %b", i, er, wr ? br[1] : rr[1]); end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL rand_stability: got %0d violations want 0", viol); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_basic();
    test_write_split();
    test_read_err_hold();
    test_addr_align();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
